// File: rtl/alu_serial_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_serial_sequencer
// Description : Bit-serial ALU sequencer. Drives one external combinational
//               1-bit ALU slice for WIDTH cycles, LSB first. The ripple carry
//               is held in a register between cycles. SLT takes one extra
//               fix-up cycle that feeds the sign decision into the slice's
//               less input.
//
// Ports       : clk, rst_n          - clock (rising edge), async active-low reset
//               start, op, a, b    - request, {Aluop2,Aluop1,Aluop0}, operands
//               busy, done         - in progress / one-cycle completion pulse
//               result, zero,
//               overflow           - registered result and flags, held
//                                    until the next done
//               slice_*            - connections to the external 1-bit slice
// Revision    : 1.0 - initial release
// ============================================================================
module alu_serial_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             slice_a,
    output logic             slice_b,
    output logic             slice_cin,
    output logic             slice_aluop2,
    output logic             slice_aluop1,
    output logic             slice_aluop0,
    output logic             slice_less,
    input  logic             slice_cout,
    input  logic             slice_r
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_SLT_FIX = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_last_bit = CNT_W'(WIDTH - 1);

    state_t             r_state;
    state_t             w_state_nxt;

    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-1:0]   r_res_sh;
    logic [2:0]         r_op;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_carry;
    logic               r_ovf;
    logic               r_set;
    logic               r_done;
    logic [WIDTH-1:0]   r_result;
    logic               r_zero;
    logic               r_overflow;

    logic               w_last;
    logic               w_ovf_bit;
    logic               w_is_slt;

    assign w_last    = (r_cnt == c_last_bit);
    // Carry into the MSB differs from carry out of the MSB -> signed overflow.
    assign w_ovf_bit = r_carry ^ slice_cout;
    assign w_is_slt  = (r_op[1:0] == 2'b11);

    assign busy      = (r_state == S_RUN) || (r_state == S_SLT_FIX);
    assign done      = r_done;
    assign result    = r_result;
    assign zero      = r_zero;
    assign overflow  = r_overflow;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next state and slice drive. Slice outputs depend only on state and
    // registers, so there is no combinational path from start/a/b.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        slice_a      = 1'b0;
        slice_b      = 1'b0;
        slice_cin    = 1'b0;
        slice_aluop2 = 1'b0;
        slice_aluop1 = 1'b0;
        slice_aluop0 = 1'b0;
        slice_less   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                slice_a      = r_a_sh[0];
                slice_b      = r_b_sh[0];
                slice_cin    = r_carry;
                slice_aluop2 = r_op[2];
                // SLT runs the body as a subtraction; the less mux is only
                // selected in the fix-up cycle.
                if (w_is_slt) begin
                    slice_aluop1 = 1'b1;
                    slice_aluop0 = 1'b0;
                end else begin
                    slice_aluop1 = r_op[1];
                    slice_aluop0 = r_op[0];
                end
                if (w_last) begin
                    w_state_nxt = w_is_slt ? S_SLT_FIX : S_DONE;
                end
            end
            S_SLT_FIX: begin
                slice_aluop1 = 1'b1;
                slice_aluop0 = 1'b1;
                slice_less   = r_set;
                w_state_nxt  = S_DONE;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh     <= '0;
            r_b_sh     <= '0;
            r_res_sh   <= '0;
            r_op       <= '0;
            r_cnt      <= '0;
            r_carry    <= 1'b0;
            r_ovf      <= 1'b0;
            r_set      <= 1'b0;
            r_done     <= 1'b0;
            r_result   <= '0;
            r_zero     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a_sh  <= a;
                        r_b_sh  <= b;
                        r_op    <= op;
                        r_cnt   <= '0;
                        // Aluop2 inverts B; a carry-in of 1 completes the
                        // two's complement negation for SUB/SLT.
                        r_carry <= op[2];
                    end
                end
                S_RUN: begin
                    r_res_sh <= {slice_r, r_res_sh[WIDTH-1:1]};
                    r_a_sh   <= r_a_sh >> 1;
                    r_b_sh   <= r_b_sh >> 1;
                    r_carry  <= slice_cout;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_ovf <= w_ovf_bit;
                        // Sign of the difference corrected for overflow.
                        r_set <= slice_r ^ w_ovf_bit;
                    end
                end
                S_SLT_FIX: begin
                    r_res_sh <= {{(WIDTH-1){1'b0}}, slice_r};
                end
                S_DONE: begin
                    r_result   <= r_res_sh;
                    r_zero     <= (r_res_sh == '0);
                    r_overflow <= (r_op[1:0] == 2'b10) ? r_ovf : 1'b0;
                    r_done     <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/alu_serial_sequencer.md
Name: alu_serial_sequencer

Overview:
- Multi-cycle sequencer that time-shares one external combinational 1-bit ALU slice (ai/bi/ci/Aluop2/lessi/Aluop0/Aluop1 -> cci/ri) to compute a full WIDTH-bit ALU operation.
- Processes operands LSB-first, one bit per clock, and registers the ripple carry between cycles.
- For SLT it adds one fix-up cycle that drives the slice's less input.
- Used as the low-area ALU path for the multi-cycle variant of the MIPS core.

Parameters:
- WIDTH, 32, operand/result width in bits (>=2).
- CNT_W, 6, bit-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; accepted only in IDLE.
- op  in  3  {Aluop2,Aluop1,Aluop0}: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
- a  in  WIDTH  operand A, sampled at accept.
- b  in  WIDTH  operand B, sampled at accept.
- busy  out  1  high in RUN and SLT_FIX.
- done  out  1  one-cycle pulse; result, zero and overflow valid from this cycle onward.
- result  out  WIDTH  final result, held until the next done.
- zero  out  1  result == 0.
- overflow  out  1  signed overflow for ADD/SUB; 0 for all other ops.
- slice_a  out  1  to slice ai.
- slice_b  out  1  to slice bi.
- slice_cin  out  1  to slice ci.
- slice_aluop2  out  1  to slice Aluop2.
- slice_aluop1  out  1  to slice Aluop1.
- slice_aluop0  out  1  to slice Aluop0.
- slice_less  out  1  to slice lessi.
- slice_cout  in  1  from slice cci.
- slice_r  in  1  from slice ri.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - busy, done, result, zero, overflow, all slice_* outputs and all internal registers go to 0.
  - Reset during RUN or SLT_FIX aborts the operation; no done is produced.
- States: IDLE, RUN, SLT_FIX, DONE.
- IDLE:
  - When start=1: latch a into a_sh, b into b_sh, op into op_r; cnt<=0; carry<=op[2]; go to RUN.
  - When start=0: stay in IDLE.
- RUN (one bit per cycle):
  - Combinational drive: slice_a=a_sh[0], slice_b=b_sh[0], slice_cin=carry, slice_aluop2=op_r[2], slice_less=0.
  - {slice_aluop1,slice_aluop0} = 2'b10 when op_r[1:0]==11, otherwise op_r[1:0].
  - Each edge: res_sh<={slice_r,res_sh[WIDTH-1:1]}; a_sh and b_sh shift right by 1; carry<=slice_cout; cnt<=cnt+1.
  - When cnt==WIDTH-1:
    - Capture ovf = carry ^ slice_cout (carry into MSB vs carry out of MSB).
    - Capture set = slice_r ^ ovf.
    - Go to SLT_FIX if op_r[1:0]==11, else DONE.
- SLT_FIX (one cycle):
  - Drive slice_aluop1/0=11, slice_less=set; slice_a, slice_b, slice_cin=0.
  - result-to-be = {WIDTH-1 zeros, slice_r}.
  - Go to DONE.
- DONE (one cycle):
  - Register result, zero and overflow; assert done=1; go to IDLE.
  - overflow = ovf only when op_r[1:0]==10, else 0.
- Latency:
  - Accept edge to done-high edge is WIDTH+1 cycles for AND/OR/ADD/SUB, WIDTH+2 for SLT.
  - Back-to-back: start may be asserted in the cycle after done.
- start in RUN, SLT_FIX or DONE is ignored; there is no queuing.
- Operand inputs may change freely after the accept edge.
- Undefined ops (011, 100, 101):
  - Executed with the same rules (Aluop2 applied, [1:0]==11 takes the SLT path).
  - The result is not guaranteed correct for the bench.
- slice_* outputs are combinational from state and registers only; no combinational path from start, a or b.
- In IDLE and DONE all slice_* outputs are 0.

Test Plan:
- Reset, then op=010, a=5, b=3, start one cycle -> busy for 32 cycles; done at accept+33; result=8, zero=0, overflow=0.
- op=110, a=3, b=5 -> result=0xFFFFFFFE, overflow=0. Then op=110, a=b=0x1234 -> result=0, zero=1.
- op=111, a=0xFFFFFFFF, b=1 -> result=1, done at accept+34. op=111, a=0x7FFFFFFF, b=0x80000000 -> result=0 (overflow-corrected set), overflow output=0.
- op=010, a=0x7FFFFFFF, b=1 -> result=0x80000000, overflow=1. op=000 / 001 with a=0xF0F0F0F0, b=0xFF00FF00 -> 0xF000F000 / 0xFFF0FFF0.
- Pulse start again at cycle 10 of a busy ADD with different operands -> ignored; first result is unchanged and exactly one done is produced.
- Drop rst_n at RUN cycle 15 -> all outputs 0 asynchronously, no done. Release, start op=001 a=1 b=2 -> result=3.
